// File: rtl/rob_commit_pkg.sv
// Shared definitions for the reorder buffer / commit stage.
//   TAG_W / TAG_NONE : tag width and the "no producer" tag
//   REG_W / NUM_REGS : architectural register index width and count
//   rob_entry_t      : per-slot state of the reorder buffer
//   flush_cause_e    : why the commit stage is redirecting the front end
package rob_commit_pkg;

  localparam int unsigned TAG_W    = 5;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [REG_W-1:0] rd;
    logic [31:0]      value;
    logic             is_br;
    logic             pred;
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      pc;
  } rob_entry_t;

  typedef enum logic [0:0] {
    FLUSH_NONE       = 1'b0,
    FLUSH_MISPREDICT = 1'b1
  } flush_cause_e;

endpackage

// File: rtl/rob_lastwriter.sv
// Last-writer table: for every architectural register, the tag of the
// youngest in-flight instruction that writes it.
//   clk_i, rst_ni            : clock, async active-low reset
//   set_i/set_rd_i/set_tag_i : record a newly renamed writer (accepted issue)
//   clr_i/clr_rd_i/clr_tag_i : register write being committed by tag clr_tag_i
//   flush_i                  : invalidate the whole table
//   modify_entry_o           : tag the register file should keep as producer
//                              after the commit (0 = value is now final)
module rob_lastwriter
  import rob_commit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_rd_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_rd_i,
  input  logic [TAG_W-1:0] clr_tag_i,
  input  logic             flush_i,
  output logic [TAG_W-1:0] modify_entry_o
);

  logic [TAG_W-1:0]    lw_tag_q [NUM_REGS];
  logic [NUM_REGS-1:0] lw_valid_q;

  logic same_cycle, still_last, clear_now;

  // A same-cycle rename of the committed register makes the new issue the
  // youngest writer, regardless of what the table currently holds.
  assign same_cycle = set_i && (set_rd_i == clr_rd_i);
  assign still_last = lw_valid_q[clr_rd_i] && (lw_tag_q[clr_rd_i] == clr_tag_i);
  assign clear_now  = clr_i && !same_cycle && still_last;

  always_comb begin
    modify_entry_o = TAG_NONE;
    if (clr_i) begin
      if (same_cycle)               modify_entry_o = set_tag_i;
      else if (still_last)          modify_entry_o = TAG_NONE;
      else if (lw_valid_q[clr_rd_i]) modify_entry_o = lw_tag_q[clr_rd_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lw_valid_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) lw_tag_q[i] <= TAG_NONE;
    end else if (flush_i) begin
      lw_valid_q <= '0;
    end else begin
      if (clear_now) lw_valid_q[clr_rd_i] <= 1'b0;
      if (set_i) begin
        lw_tag_q[set_rd_i]   <= set_tag_i;
        lw_valid_q[set_rd_i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit.
//   clk_in, rst_n_in, rdy_in         : clock, async active-low reset, global stall (low)
//   issue_*, full, issue_tag         : dispatch side; tag = slot + 1
//   reorder, reorder_entry/rd        : rename write into the register file
//   cdb_*                            : result / branch outcome broadcast
//   query_tag/ready/value            : operand forwarding lookup (with CDB bypass)
//   modify, modify_entry/index/value : commit write into the register file
//   flush_out, flush_pc              : redirect on committed mispredict
// All outputs are combinational from registered state and current inputs.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_is_br,
  input  logic             issue_pred_taken,
  input  logic [31:0]      issue_pc,
  output logic             full,
  output logic [TAG_W-1:0] issue_tag,
  output logic             reorder,
  output logic [TAG_W-1:0] reorder_entry,
  output logic [REG_W-1:0] reorder_rd,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] query_tag,
  output logic             query_ready,
  output logic [31:0]      query_value,
  output logic             modify,
  output logic [TAG_W-1:0] modify_entry,
  output logic [REG_W-1:0] modify_index,
  output logic [31:0]      modify_value,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  rob_entry_t   head_e;
  logic         commit, accept, do_modify, mispred;
  flush_cause_e flush_cause;
  logic [TAG_W-1:0] head_tag, lw_entry;

  assign head_e   = ent_q[head_q];
  assign head_tag = TAG_W'(head_q) + TAG_W'(1);

  assign full      = (count_q == CNT_W'(DEPTH));
  assign issue_tag = TAG_W'(tail_q) + TAG_W'(1);

  // Commit and its consequences
  assign commit      = rdy_in && head_e.busy && head_e.ready;
  assign do_modify   = commit && !head_e.is_br && (head_e.rd != '0);
  assign mispred     = commit && head_e.is_br && (head_e.taken != head_e.pred);
  assign flush_cause = mispred ? FLUSH_MISPREDICT : FLUSH_NONE;
  assign flush_out   = (flush_cause != FLUSH_NONE);
  assign flush_pc    = !flush_out   ? 32'd0 :
                       head_e.taken ? head_e.target : head_e.pc + 32'd4;

  // An issue landing in the flush cycle belongs to the wrong path.
  assign accept = issue_valid && !full && rdy_in && !flush_out;

  assign reorder       = accept && (issue_rd != '0);
  assign reorder_entry = reorder ? issue_tag : TAG_NONE;
  assign reorder_rd    = reorder ? issue_rd  : '0;

  assign modify       = do_modify;
  assign modify_entry = do_modify ? lw_entry     : TAG_NONE;
  assign modify_index = do_modify ? head_e.rd    : '0;
  assign modify_value = do_modify ? head_e.value : 32'd0;

  rob_lastwriter u_lw (
    .clk_i          (clk_in),
    .rst_ni         (rst_n_in),
    .set_i          (reorder),
    .set_rd_i       (issue_rd),
    .set_tag_i      (issue_tag),
    .clr_i          (do_modify),
    .clr_rd_i       (head_e.rd),
    .clr_tag_i      (head_tag),
    .flush_i        (flush_out),
    .modify_entry_o (lw_entry)
  );

  // Forwarding: a same-cycle CDB hit wins over the stored value.
  always_comb begin
    query_ready = 1'b0;
    query_value = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (query_tag == TAG_W'(i + 1) && ent_q[i].busy) begin
        if (cdb_valid && cdb_tag == query_tag) begin
          query_ready = 1'b1;
          query_value = cdb_value;
        end else if (ent_q[i].ready) begin
          query_ready = 1'b1;
          query_value = ent_q[i].value;
        end
      end
    end
  end

  // Next state of the entry array and pointers (before rdy/flush gating).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && cdb_tag == TAG_W'(i + 1) && ent_q[i].busy) begin
        ent_d[i].ready  = 1'b1;
        ent_d[i].value  = cdb_value;
        ent_d[i].taken  = cdb_taken;
        ent_d[i].target = cdb_target;
      end
    end
    if (commit) begin
      ent_d[head_q].busy  = 1'b0;
      ent_d[head_q].ready = 1'b0;
    end
    if (accept) begin
      ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: issue_rd, value: 32'd0,
                        is_br: issue_is_br, pred: issue_pred_taken, taken: 1'b0,
                        target: 32'd0, pc: issue_pc};
    end

    head_d = head_q;
    if (commit) head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
    tail_d = tail_q;
    if (accept) tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);

    count_d = count_q;
    if (accept && !commit)      count_d = count_q + CNT_W'(1);
    else if (!accept && commit) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in;
  logic        issue_valid, issue_is_br, issue_pred_taken;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        full, reorder, query_ready, modify, flush_out;
  logic [4:0]  issue_tag, reorder_entry, reorder_rd, modify_entry, modify_index;
  logic        cdb_valid, cdb_taken;
  logic [4:0]  cdb_tag, query_tag;
  logic [31:0] cdb_value, cdb_target, query_value, modify_value, flush_pc;

  int total = 0;
  int bad   = 0;

  rob_commit #(.DEPTH(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
    .full(full), .issue_tag(issue_tag),
    .reorder(reorder), .reorder_entry(reorder_entry), .reorder_rd(reorder_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .query_tag(query_tag), .query_ready(query_ready), .query_value(query_value),
    .modify(modify), .modify_entry(modify_entry), .modify_index(modify_index),
    .modify_value(modify_value), .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs are then changed 1 time unit after it
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_is_br = 0; issue_pred_taken = 0; issue_pc = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
    query_tag = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] pc);
    issue_valid = 1; issue_rd = rd; issue_is_br = br; issue_pred_taken = pred; issue_pc = pc;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val; cdb_taken = tk; cdb_target = tgt;
  endtask

  task automatic do_reset();
    idle();
    rdy_in = 1;
    rst_n_in = 0;
    #2;
    tick();
    rst_n_in = 1;
    #1;
  endtask

  initial begin
    idle();
    rdy_in = 1; rst_n_in = 1;
    #2;
    // ---- reset ----
    do_reset();
    chk("rst_full", full, 0);
    chk("rst_modify", modify, 0);
    chk("rst_issue_tag", issue_tag, 1);
    chk("rst_flush", flush_out, 0);
    chk("rst_reorder", reorder, 0);

    // ---- basic commit, rdy_in freeze, forwarding bypass ----
    issue(5, 0, 0, 32'h40); #1;
    chk("b_reorder", reorder, 1);
    chk("b_reorder_entry", reorder_entry, 1);
    chk("b_reorder_rd", reorder_rd, 5);
    tick(); idle();
    chk("b_issue_tag2", issue_tag, 2);
    cdb(1, 32'hDEAD, 0, 0); query_tag = 1; #1;
    chk("b_bypass_rdy", query_ready, 1);
    chk("b_bypass_val", query_value, 32'hDEAD);
    chk("b_no_early_commit", modify, 0);
    tick(); idle();
    rdy_in = 0; #1;
    chk("b_frozen_modify", modify, 0);
    tick();
    rdy_in = 1; query_tag = 1; #1;
    chk("b_modify", modify, 1);
    chk("b_modify_index", modify_index, 5);
    chk("b_modify_value", modify_value, 32'hDEAD);
    chk("b_modify_entry", modify_entry, 0);
    chk("b_query_stored", query_value, 32'hDEAD);
    tick(); idle(); #1;
    chk("b_retired", modify, 0);

    // ---- reset mid-run, then multiple writers of r3 ----
    issue(9, 0, 0, 0); tick(); idle();
    do_reset();
    chk("mr_issue_tag", issue_tag, 1);
    issue(3, 0, 0, 0); #1;
    chk("mw_tag1", reorder_entry, 1);
    tick();
    issue(3, 0, 0, 0); #1;
    chk("mw_tag2", reorder_entry, 2);
    tick(); idle();
    cdb(1, 32'h11, 0, 0); tick(); idle();
    cdb(2, 32'h22, 0, 0); #1;
    chk("mw_c1_modify", modify, 1);
    chk("mw_c1_value", modify_value, 32'h11);
    chk("mw_c1_entry", modify_entry, 2);
    tick(); idle(); #1;
    chk("mw_c2_value", modify_value, 32'h22);
    chk("mw_c2_entry", modify_entry, 0);
    tick();

    // ---- commit with same-cycle issue to the same register ----
    do_reset();
    issue(7, 0, 0, 0); tick(); idle();
    cdb(1, 32'h77, 0, 0); tick(); idle();
    issue(7, 0, 0, 0); #1;
    chk("sc_modify", modify, 1);
    chk("sc_modify_entry", modify_entry, 2);
    chk("sc_reorder", reorder, 1);
    chk("sc_reorder_rd", reorder_rd, 7);
    chk("sc_reorder_entry", reorder_entry, 2);
    tick(); idle();
    cdb(2, 32'h78, 0, 0); tick(); idle(); #1;
    chk("sc_c2_value", modify_value, 32'h78);
    chk("sc_c2_entry", modify_entry, 0);
    tick();

    // ---- full and wrap ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(5'(i + 1), 0, 0, 0); tick();
    end
    idle(); #1;
    chk("f_full", full, 1);
    chk("f_issue_tag_wrapped", issue_tag, 1);
    issue(20, 0, 0, 0); #1;
    chk("f_17th_ignored", reorder, 0);
    tick(); idle(); #1;
    chk("f_still_full", full, 1);
    cdb(1, 32'hAA, 0, 0); tick(); idle();
    issue(20, 0, 0, 0); #1;
    chk("f_commit_while_full", modify, 1);
    chk("f_no_issue_while_full", reorder, 0);
    chk("f_commit_entry", modify_entry, 0);
    tick(); #1;
    chk("f_not_full", full, 0);
    chk("f_wrap_reorder", reorder, 1);
    chk("f_wrap_tag", reorder_entry, 1);
    tick(); idle(); #1;
    chk("f_full_again", full, 1);

    // ---- mispredict ----
    do_reset();
    issue(0, 1, 0, 32'h100); #1;
    chk("m_branch_no_rename", reorder, 0);
    tick();
    issue(4, 0, 0, 32'h104); tick(); idle();
    cdb(1, 0, 1, 32'h200); tick(); idle();
    issue(9, 0, 0, 0); #1;
    chk("m_flush", flush_out, 1);
    chk("m_flush_pc", flush_pc, 32'h200);
    chk("m_no_modify", modify, 0);
    chk("m_issue_discarded", reorder, 0);
    tick(); idle(); query_tag = 2; #1;
    chk("m_after_tag", issue_tag, 1);
    chk("m_after_full", full, 0);
    chk("m_after_flush", flush_out, 0);
    chk("m_entry_cleared", query_ready, 0);
    // predicted taken, resolved not taken -> fall-through
    issue(0, 1, 1, 32'h300); tick(); idle();
    cdb(1, 0, 0, 32'h500); tick(); idle(); #1;
    chk("m2_flush", flush_out, 1);
    chk("m2_flush_pc", flush_pc, 32'h304);
    tick(); idle();
    // CDB to an empty buffer is ignored
    cdb(5, 32'h55, 0, 0); tick(); idle(); query_tag = 5; #1;
    chk("e_cdb_ignored", query_ready, 0);
    chk("e_no_commit", modify, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit stage for the out-of-order core. Allocates a 5-bit tag per dispatched instruction and drives the register file's rename port (`reorder*`). Captures results from the common data bus and forwards ready values to dispatch. Retires the head entry into the register file's write port (`modify*`) and raises a pipeline flush on a committed branch mispredict.

## Interface
- `DEPTH`, 16: number of entries (max 31). Tag = slot index + 1, so valid tags are 1..DEPTH; tag 0 means "no producer".
- `clk_in` input 1: clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: global ready; low freezes all state.
- `issue_valid` input 1: dispatch presents an instruction.
- `issue_rd` input 5: destination register (0 = no write).
- `issue_is_br` input 1: instruction is a branch.
- `issue_pred_taken` input 1: predicted direction.
- `issue_pc` input 32: instruction PC.
- `full` output 1: no free slot; issue is ignored while high.
- `issue_tag` output 5: tag that the current issue will receive.
- `reorder`, `reorder_entry[4:0]`, `reorder_rd[4:0]` outputs: rename write to the register file.
- `cdb_valid` input 1, `cdb_tag` input 5, `cdb_value` input 32: result broadcast.
- `cdb_taken` input 1, `cdb_target` input 32: branch outcome, used when the entry is a branch.
- `query_tag` input 5, `query_ready` output 1, `query_value` output 32: operand forwarding lookup.
- `modify`, `modify_entry[4:0]`, `modify_index[4:0]`, `modify_value[31:0]` outputs: commit write to the register file.
- `flush_out` output 1, `flush_pc` output 32: mispredict redirect.

## Operation
- **State**
  - Per entry: `busy`, `ready`, `rd`, `value`, `is_br`, `pred`, `taken`, `target`, `pc`.
  - Pointers: `head`, `tail`, `count` (0..DEPTH).
  - Last-writer table: `lw_tag[32]`, `lw_valid[32]`.
- **Issue accept:** `issue_valid & !full & rdy_in`.
  - Fills slot `tail`, with `busy`=1 and `ready`=0.
  - `tail` wraps DEPTH-1 → 0.
  - If `issue_rd`≠0, sets the last-writer entry for that register to `issue_tag`.
- **Rename outputs (combinational):**
  - `reorder` = accept & `issue_rd`≠0.
  - `reorder_entry` = `issue_tag`; `reorder_rd` = `issue_rd`.
  - `issue_tag` = `tail`+1.
- **CDB write:** `cdb_valid` & matching busy entry sets `ready`, `value`, `taken`, `target`. A CDB with tag 0 or a non-busy tag is ignored.
- **Commit:** fires when the head is busy & ready & `rdy_in`. One commit per cycle.
  - Non-branch with `rd`≠0:
    - `modify`=1, `modify_index`=rd, `modify_value`=value.
    - `modify_entry` = 0 if the head tag is still the last writer of rd and no same-cycle issue targets rd. In that case also clear `lw_valid[rd]`.
    - Otherwise `modify_entry` = the youngest writer's tag. A same-cycle issue to rd takes priority, so `modify_entry` = `issue_tag`.
  - `rd`=0: retire silently with `modify`=0.
  - Branch: `modify`=0.
    - If `taken`≠`pred`: `flush_out`=1 and `flush_pc` = `taken` ? `target` : `pc`+4.
    - On the following edge, clear all entries, pointers, count and the last-writer table.
    - An issue in the flush cycle is discarded.
- **Forwarding:** `query_ready`=1 iff `query_tag`≠0 and the entry is busy & ready. `query_value`=value when ready, else 0.
  - A same-cycle CDB with a matching tag also returns ready with `cdb_value` (bypass).
- **Count:** +1 on accept, −1 on commit, unchanged on both, 0 on flush.

## Timing
- **Reset** (`rst_n_in` low, asynchronous): all entries not busy, pointers and count 0, last-writer table invalid. Every output reads 0 except `issue_tag`=1.
- **Output timing:** all outputs are combinational from registered state plus current inputs. The register file samples them on the same edge that updates this block.
- **Latency:** CDB write at edge N → commit eligible in cycle N+1 (earliest write-back to the register file at edge N+1). Issue-to-commit is at least 2 cycles.
- **Full:** `full` = (count==DEPTH) from registered count. An issue while full is not accepted even if a commit happens the same cycle.
- **Empty:** no commit. A CDB aimed at an empty buffer is ignored.
- **`rdy_in` low:** no state change; `reorder`, `modify` and `flush_out` are forced 0.
- **Reset mid-operation:** contents are lost immediately with no pending commit.

## Structure
- Shared core package holds:
  - tag width 5 and `TAG_NONE`=0;
  - register count 32;
  - an entry struct (busy, ready, rd, value, is_br, pred, taken, target, pc);
  - the flush-cause enum.
- Natural sub-module: `rob_lastwriter`. It holds the 32-entry last-writer table, with set (issue), conditional clear (commit) and flush ports, and computes `modify_entry`.

## Test plan
- **Reset:** hold `rst_n_in` low mid-run → `full`=0, `modify`=0, `issue_tag`=1. The next accepted issue gets tag 1.
- **Basic commit:** issue rd=5 (tag 1), CDB tag 1 value 0xDEAD → next cycle `modify`=1, `modify_index`=5, `modify_value`=0xDEAD, `modify_entry`=0.
- **Multiple writers:** issue rd=3 twice (tags 1, 2), complete both → commit of tag 1 gives `modify_entry`=2; commit of tag 2 gives `modify_entry`=0.
- **Commit with same-cycle issue:** commit head rd=7 while issuing rd=7 → `modify_entry` equals the new `issue_tag`, and `reorder`=1 with `reorder_rd`=7.
- **Full and wrap:** issue 16 instructions → `full`=1 and a 17th is ignored. Commit one, then issue → it gets tag 1 (wrap).
- **Mispredict:** a branch at pc 0x100 predicted not-taken resolves taken with target 0x200 → `flush_out`=1, `flush_pc`=0x200. Next cycle count=0 and `issue_tag`=1.
